// File: rtl/spi_master_cfg_if.sv
// Command/response bundle between a register front end and spi_master_cfg.
// Ports: tx_valid/tx_ready/tx_data/tx_ss_sel and the cfg_* fields form the command;
// rx_valid/rx_data return the captured word; busy mirrors ~tx_ready.
interface spi_master_cfg_if #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int DIV_W  = 8
);
  localparam int SEL_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;

  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic [SEL_W-1:0]  tx_ss_sel;
  logic              cfg_cpol;
  logic              cfg_cpha;
  logic [DIV_W-1:0]  cfg_div;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              busy;

  // Front end side: issues commands, consumes received words.
  modport master (
    output tx_valid, tx_data, tx_ss_sel, cfg_cpol, cfg_cpha, cfg_div,
    input  tx_ready, rx_valid, rx_data, busy
  );

  // SPI master side: accepts commands, produces received words.
  modport slave (
    input  tx_valid, tx_data, tx_ss_sel, cfg_cpol, cfg_cpha, cfg_div,
    output tx_ready, rx_valid, rx_data, busy
  );
endinterface

// File: rtl/spi_master_cfg.sv
// Purpose: SPI master, MSB first, full duplex, run-time CPOL/CPHA, SCLK half-period cfg_div+1.
// Latency: rx_valid pulses (2*DATA_W+2)*(cfg_div+1) clk after the accepting edge.
// Backpressure: tx_ready low for the whole transfer; a held tx_valid waits and is never dropped.
// Ports: clk, reset (async, active low); cmd (spi_master_cfg_if.slave) carries the
// command handshake, cfg fields, rx_valid/rx_data and busy; sclk/ss_n/mosi/miso are the SPI pins.
module spi_master_cfg #(
  parameter int DATA_W     = 8,
  parameter int NUM_SS     = 4,
  parameter int DIV_W      = 8,
  parameter bit RESET_CPOL = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  spi_master_cfg_if.slave   cmd,
  output logic              sclk,
  output logic [NUM_SS-1:0] ss_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int SEL_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
  localparam int EDGE_W = $clog2(2*DATA_W + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE  = EDGE_W'(2*DATA_W);
  localparam logic [EDGE_W-1:0] FIRST_EDGE = EDGE_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL} state_t;

  state_t            state_q, state_d;
  logic [DIV_W:0]    cnt_q;      // one bit wider so cfg_div = all ones never wraps
  logic [DIV_W-1:0]  div_q;
  logic              cpol_q;
  logic              cpha_q;
  logic [EDGE_W-1:0] edge_q;     // sclk edges generated so far in this transfer
  logic [EDGE_W-1:0] edge_nxt;
  logic [DATA_W-1:0] tx_sh_q;
  logic [DATA_W-1:0] rx_sh_q;
  logic [NUM_SS-1:0] ss_dec;

  logic accept, seg_done, do_edge, leading, sample, drive, finish;

  assign accept   = cmd.tx_valid && (state_q == S_IDLE);
  // Every D-cycle segment ends when the counter reaches the latched divider.
  assign seg_done = (cnt_q == {1'b0, div_q});
  assign edge_nxt = edge_q + FIRST_EDGE;
  assign leading  = edge_nxt[0];
  // Edge k sits at the end of the k-th segment counted from the start of LEAD;
  // the final XFER segment ends on the transition into TRAIL without a toggle.
  assign do_edge  = seg_done && ((state_q == S_LEAD) ||
                                 ((state_q == S_XFER) && (edge_q != LAST_EDGE)));
  assign sample   = do_edge && (cpha_q ? !leading : leading);
  // CPHA=1 keeps the MSB through the first leading edge; CPHA=0 drives nothing after the last edge.
  assign drive    = do_edge && (cpha_q ? (leading && (edge_nxt != FIRST_EDGE))
                                       : (!leading && (edge_nxt != LAST_EDGE)));
  assign finish   = (state_q == S_TRAIL) && seg_done;

  assign cmd.tx_ready = (state_q == S_IDLE);
  assign cmd.busy     = (state_q != S_IDLE);
  // tx_sh_q is cleared outside a transfer, so mosi idles low.
  assign mosi         = tx_sh_q[DATA_W-1];

  // An out-of-range select leaves every line high while the transfer still runs.
  always_comb begin
    ss_dec = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      ss_dec[i] = (cmd.tx_ss_sel != SEL_W'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)                            state_d = S_LEAD;
      S_LEAD:  if (seg_done)                          state_d = S_XFER;
      S_XFER:  if (seg_done && (edge_q == LAST_EDGE)) state_d = S_TRAIL;
      S_TRAIL: if (seg_done)                          state_d = S_IDLE;
      default:                                        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      div_q        <= '0;
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      edge_q       <= '0;
      tx_sh_q      <= '0;
      rx_sh_q      <= '0;
      sclk         <= RESET_CPOL;
      ss_n         <= '1;
      cmd.rx_valid <= 1'b0;
      cmd.rx_data  <= '0;
    end else begin
      cmd.rx_valid <= 1'b0;
      if (state_q == S_IDLE) begin
        // Idle sclk follows the live polarity so the bus settles before a select falls.
        sclk  <= cmd.cfg_cpol;
        cnt_q <= '0;
        if (accept) begin
          div_q   <= cmd.cfg_div;
          cpol_q  <= cmd.cfg_cpol;
          cpha_q  <= cmd.cfg_cpha;
          tx_sh_q <= cmd.tx_data;
          rx_sh_q <= '0;
          edge_q  <= '0;
          ss_n    <= ss_dec;
        end
      end else begin
        cnt_q <= seg_done ? '0 : cnt_q + 1'b1;
        if (do_edge) begin
          sclk   <= ~sclk;
          edge_q <= edge_nxt;
        end else if (state_q != S_XFER) begin
          sclk <= cpol_q;
        end
        if (sample) rx_sh_q <= {rx_sh_q[DATA_W-2:0], miso};
        if (drive)  tx_sh_q <= {tx_sh_q[DATA_W-2:0], 1'b0};
        if (finish) begin
          ss_n         <= '1;
          tx_sh_q      <= '0;
          cmd.rx_data  <= rx_sh_q;
          cmd.rx_valid <= 1'b1;
        end
      end
    end
  end

endmodule
